pong_game_ctrl: RTL

Game-flow controller sequencing the ball datapath of the Pong design. Consumes the per-frame tick and the ball's miss events. Decides when the ball is held at centre, when it moves and in which direction it is served. Owns the two BCD score registers and declares the winner; the ball block becomes a pure motion/render datapath gated by this controller.

---
 rtl/pong_game_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Game-flow controller for Pong: holds/serves the ball, times the serve and
// point pauses in frame ticks, keeps both BCD scores and declares the winner.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic       i_start,
    input  logic       i_miss_left,
    input  logic       i_miss_right,
    output logic       o_ball_run,
    output logic       o_ball_hold,
    output logic       o_serve_dir,
    output logic [3:0] o_score1,
    output logic [3:0] o_score2,
    output logic       o_point,
    output logic       o_game_over,
    output logic       o_winner,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SERVE    = 3'd1,
        S_PLAY     = 3'd2,
        S_POINT    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       start_q;
    logic       start_rise;
    logic [7:0] frame_cnt;
    logic [7:0] frame_last;
    logic       timed;
    logic       expire;
    logic       inc1;
    logic       inc2;
    logic       clear_game;

    // Frame timer: a timed state expires on the tick that arrives at count N-1.
    always_comb begin
        timed      = (state == S_SERVE) || (state == S_POINT);
        frame_last = (state == S_SERVE) ? 8'(SERVE_FRAMES - 1) : 8'(POINT_FRAMES - 1);
        expire     = timed && i_frame_tick && (frame_cnt == frame_last);
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        inc1       = 1'b0;
        inc2       = 1'b0;
        clear_game = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise) state_nxt = S_SERVE;
            end
            S_SERVE: begin
                if (expire) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (i_miss_left && i_miss_right) begin
                    state_nxt = S_SERVE;
                end else if (i_miss_right) begin
                    inc1      = 1'b1;
                    state_nxt = (o_score1 + 4'd1 == 4'(WIN_SCORE)) ? S_GAMEOVER : S_POINT;
                end else if (i_miss_left) begin
                    inc2      = 1'b1;
                    state_nxt = (o_score2 + 4'd1 == 4'(WIN_SCORE)) ? S_GAMEOVER : S_POINT;
                end
            end
            S_POINT: begin
                if (expire) state_nxt = S_SERVE;
            end
            S_GAMEOVER: begin
                if (start_rise) begin
                    clear_game = 1'b1;
                    state_nxt  = S_SERVE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            start_q     <= 1'b1;  // a button held through reset must not look like a press
            start_rise  <= 1'b0;
            frame_cnt   <= 8'd0;
            o_ball_run  <= 1'b0;
            o_ball_hold <= 1'b1;
            o_serve_dir <= 1'b0;
            o_score1    <= 4'd0;
            o_score2    <= 4'd0;
            o_point     <= 1'b0;
            o_game_over <= 1'b0;
            o_winner    <= 1'b0;
        end else begin
            start_q     <= i_start;
            start_rise  <= i_start && !start_q;
            state       <= state_nxt;
            o_ball_run  <= (state_nxt == S_PLAY);
            o_ball_hold <= (state_nxt != S_PLAY);
            o_game_over <= (state_nxt == S_GAMEOVER);
            o_point     <= inc1 || inc2;

            // Any state change restarts the timer, which also drops an entry-cycle tick.
            if (state_nxt != state) begin
                frame_cnt <= 8'd0;
            end else if (timed && i_frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (clear_game) begin
                o_score1    <= 4'd0;
                o_score2    <= 4'd0;
                o_serve_dir <= 1'b0;
                o_winner    <= 1'b0;
            end else if (inc1) begin
                o_score1    <= o_score1 + 4'd1;
                o_serve_dir <= 1'b0;
                if (state_nxt == S_GAMEOVER) o_winner <= 1'b0;
            end else if (inc2) begin
                o_score2    <= o_score2 + 4'd1;
                o_serve_dir <= 1'b1;
                if (state_nxt == S_GAMEOVER) o_winner <= 1'b1;
            end
        end
    end

    assign o_state = state;

endmodule
